// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync/pixel decoder; define ERR_COUNT_EN to add err_count
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOSS_THRESH = 4
) (
    input  logic        clk_25MHz,
    input  logic        reset_n,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic        Red,
    input  logic        Green,
    input  logic        Blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
`ifdef ERR_COUNT_EN
    output logic [15:0] err_count,
`endif
    output logic        timing_err
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] POS_MAX  = 10'h3FF;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] H_BEG    = 10'(H_START);
    localparam logic [9:0] H_END    = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] V_BEG    = 10'(V_START);
    localparam logic [9:0] V_END    = 10'(V_START + V_ACTIVE);
    localparam logic [7:0] LOSS_N   = 8'(LOSS_THRESH);

    logic       s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [2:0] s1_rgb_q, s1_rgb_d;
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
    state_t     state_q, state_d;
    logic [7:0] err_run_q, err_run_d;
    logic       line_err_q, line_err_d;
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [8:0] pix_y_q, pix_y_d;
    logic [2:0] pix_rgb_q, pix_rgb_d;
    logic       frame_start_q, frame_start_d;
    logic       timing_err_q, timing_err_d;

    logic hs_rise, hs_fall, vs_rise, vs_fall, lost_h, chk_err, in_win;

    // Stage 1 capture plus the previous sync samples for edge detection
    always_comb begin
        s1_hs_d   = Hsync;
        s1_vs_d   = Vsync;
        s1_rgb_d  = {Blue, Green, Red};
        hs_prev_d = s1_hs_q;
        vs_prev_d = s1_vs_q;
    end

    assign hs_rise = s1_hs_q & ~hs_prev_q;
    assign hs_fall = ~s1_hs_q & hs_prev_q;
    assign vs_rise = s1_vs_q & ~vs_prev_q;
    assign vs_fall = ~s1_vs_q & vs_prev_q;

    // Position of the current stage-1 sample; h_pos_q/v_pos_q hold the previous one
    always_comb begin
        h_pos_d = h_pos_q;
        v_pos_d = v_pos_q;
        if (hs_rise) begin
            h_pos_d = 10'd0;
        end else if (h_pos_q != POS_MAX) begin
            h_pos_d = h_pos_q + 10'd1;
        end
        if (vs_rise) begin
            v_pos_d = 10'd0;
        end else if (hs_rise && (v_pos_q != POS_MAX)) begin
            v_pos_d = v_pos_q + 10'd1;
        end
    end

    assign lost_h  = (h_pos_d == POS_MAX) && (h_pos_q != POS_MAX);
    assign chk_err = (hs_rise && (h_pos_q != H_LAST))
                   || (hs_fall && (h_pos_d != H_SYNC_W))
                   || (vs_rise && (v_pos_q != V_LAST))
                   || (vs_fall && (!hs_rise || (v_pos_d != V_SYNC_W)))
                   || lost_h;

    // Lock FSM: acquisition, per-line error run tracking, pulse generation
    always_comb begin
        state_d       = state_q;
        err_run_d     = err_run_q;
        line_err_d    = line_err_q;
        frame_start_d = 1'b0;
        timing_err_d  = chk_err && (state_q != ST_SEARCH);
        case (state_q)
            ST_SEARCH: begin
                err_run_d  = 8'd0;
                line_err_d = 1'b0;
                if (vs_rise) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                err_run_d  = 8'd0;
                line_err_d = 1'b0;
                if (chk_err) begin
                    state_d = ST_SEARCH;
                end else if (vs_rise) begin
                    state_d       = ST_LOCKED;
                    frame_start_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (vs_rise && !chk_err) frame_start_d = 1'b1;
                if (lost_h) begin
                    state_d    = ST_SEARCH;
                    err_run_d  = 8'd0;
                    line_err_d = 1'b0;
                end else if (hs_rise) begin
                    // the rise closes the line, so an error on the rise itself counts for it
                    line_err_d = 1'b0;
                    if (line_err_q || chk_err) begin
                        err_run_d = err_run_q + 8'd1;
                        if ((err_run_q + 8'd1) >= LOSS_N) begin
                            state_d   = ST_SEARCH;
                            err_run_d = 8'd0;
                        end
                    end else begin
                        err_run_d = 8'd0;
                    end
                end else if (chk_err) begin
                    line_err_d = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Stage 2 pixel output, zeroed outside the locked active window
    always_comb begin
        in_win      = (state_q == ST_LOCKED)
                    && (h_pos_d >= H_BEG) && (h_pos_d < H_END)
                    && (v_pos_d >= V_BEG) && (v_pos_d < V_END);
        pix_valid_d = in_win;
        pix_x_d     = in_win ? (h_pos_d - H_BEG) : 10'd0;
        pix_y_d     = in_win ? 9'(v_pos_d - V_BEG) : 9'd0;
        pix_rgb_d   = in_win ? s1_rgb_q : 3'd0;
    end

    // All decoder state, cleared asynchronously
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            s1_rgb_q      <= 3'd0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_pos_q       <= 10'd0;
            v_pos_q       <= 10'd0;
            state_q       <= ST_SEARCH;
            err_run_q     <= 8'd0;
            line_err_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 9'd0;
            pix_rgb_q     <= 3'd0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s1_rgb_q      <= s1_rgb_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            state_q       <= state_d;
            err_run_q     <= err_run_d;
            line_err_q    <= line_err_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            timing_err_q  <= timing_err_d;
        end
    end

`ifdef ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating count of timing_err pulses, cleared only by reset
    always_comb begin
        err_count_d = err_count_q;
        if (timing_err_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
    end

    // Error counter register
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) err_count_q <= 16'd0;
        else          err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == ST_LOCKED);
    assign timing_err  = timing_err_q;

endmodule
